// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: lane count, lane mask and lane-count types.
// Used by the 4-write/1-read FIFO and its 1-write/4-read sibling.
package fifo_pkg;

    localparam int NUM_WR_LANES = 4;

    typedef logic [NUM_WR_LANES-1:0] lane_mask_t;
    typedef logic [2:0]              lane_cnt_t;

    function automatic lane_cnt_t popcnt4(input lane_mask_t m);
        lane_cnt_t n;
        n = '0;
        for (int i = 0; i < NUM_WR_LANES; i++) begin
            n = n + lane_cnt_t'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_w4r1_if.sv
// Handshake bundle for fifo_w4r1: four write lanes in, one beat out.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_w4r1_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    import fifo_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    lane_mask_t       valid_in;
    lane_mask_t       ready_in;
    logic [WIDTH-1:0] data_in [3:0];
    logic             ready_out;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;

    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, count
    );

    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, count
    );

endinterface

// File: rtl/fifo_w4r1_lane_compact4.sv
// Packs accepted write lanes into consecutive slots in lane order.
// Ports: acc_i mask, data_i[4] in; data_o[4] packed, n_wr_o count out.
module lane_compact4
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  lane_mask_t       acc_i,
    input  logic [WIDTH-1:0] data_i [3:0],
    output logic [WIDTH-1:0] data_o [3:0],
    output lane_cnt_t        n_wr_o
);

    lane_cnt_t n;

    // Slot k receives the k-th set lane, scanning lane 0 upward.
    always_comb begin
        for (int k = 0; k < NUM_WR_LANES; k++) begin
            data_o[k] = '0;
        end
        n = '0;
        for (int i = 0; i < NUM_WR_LANES; i++) begin
            if (acc_i[i]) begin
                data_o[n[1:0]] = data_i[i];
                n = n + 3'd1;
            end
        end
    end

    assign n_wr_o = n;

endmodule

// File: rtl/fifo_w4r1.sv
// Synchronous FIFO, four compacted write lanes, one FWFT read port.
// Ports: clk, reset (sync, active-high), bus (fifo_w4r1_if.slave).
module fifo_w4r1
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    fifo_w4r1_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [CW-1:0]    free;
    lane_mask_t       rdy;
    lane_mask_t       acc;
    lane_cnt_t        n_wr;
    logic             rd;
    logic [WIDTH-1:0] pk [3:0];

    // Grants come from registered count only, so no valid->ready path
    // and a same-cycle read never widens the grant.
    assign free = CW'(DEPTH) - count_q;

    always_comb begin
        rdy = '0;
        for (int i = 0; i < NUM_WR_LANES; i++) begin
            rdy[i] = (free >= CW'(i + 1));
        end
    end

    assign acc = bus.valid_in & rdy;
    assign rd  = (count_q != '0) && bus.ready_out;

    lane_compact4 #(
        .WIDTH (WIDTH)
    ) u_compact (
        .acc_i  (acc),
        .data_i (bus.data_in),
        .data_o (pk),
        .n_wr_o (n_wr)
    );

    // Pointer adds wrap naturally at AW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(n_wr);
        rd_ptr_d = rd_ptr_q + AW'(rd);
        count_d  = count_q + CW'(n_wr) - CW'(rd);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_WR_LANES; k++) begin
                if (3'(k) < n_wr) begin
                    mem_q[wr_ptr_q + AW'(k)] <= pk[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.ready_in  = rdy;
    assign bus.valid_out = (count_q != '0);
    assign bus.data_out  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_fifo_w4r1.sv
// Scoreboard bench for fifo_w4r1: directed cases plus random traffic.
// Monitor on negedge tracks pushes/pops and expected count/grants.
module tb_fifo_w4r1;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;

    fifo_w4r1_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_w4r1 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [WIDTH-1:0] sb [$];
    int mcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      tag, obs, exp, $time);
    endtask

    function automatic logic [3:0] exp_rdy(input int c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ((DEPTH - c) >= i + 1);
        return r;
    endfunction

    // Inputs change at posedge+1, so negedge sees what the next edge commits.
    always @(negedge clk) begin
        int nw;
        int rd;
        if (reset) begin
            sb.delete();
            mcnt = 0;
        end else begin
            chk("cnt", 32'(bus.count), 32'(mcnt));
            chk("rdy", 32'(bus.ready_in), 32'(exp_rdy(mcnt)));
            chk("vld", 32'(bus.valid_out), 32'(mcnt != 0));
            rd = 0;
            if (bus.valid_out && bus.ready_out) begin
                if (sb.size() == 0) chk("underrun", 32'd1, 32'd0);
                else chk("dout", 32'(bus.data_out), 32'(sb.pop_front()));
                rd = 1;
            end
            nw = 0;
            for (int i = 0; i < 4; i++) begin
                if (bus.valid_in[i] && bus.ready_in[i]) begin
                    sb.push_back(bus.data_in[i]);
                    nw++;
                end
            end
            mcnt = mcnt + nw - rd;
        end
    end

    task automatic idle();
        bus.valid_in  = 4'b0000;
        bus.ready_out = 1'b0;
        for (int i = 0; i < 4; i++) bus.data_in[i] = '0;
    endtask

    // One cycle of stimulus; returns at posedge+1 with inputs idle.
    task automatic cyc(input logic [3:0] v, input logic [31:0] d,
                       input logic ro);
        bus.valid_in  = v;
        bus.ready_out = ro;
        for (int i = 0; i < 4; i++) bus.data_in[i] = d[8*i +: 8];
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_rdy",  32'(bus.ready_in),  32'hF);
        chk("rst_vld",  32'(bus.valid_out), 32'h0);
        chk("rst_dout", 32'(bus.data_out),  32'h0);
        chk("rst_cnt",  32'(bus.count),     32'h0);

        // Full 4-lane burst then ordered drain.
        cyc(4'b1111, 32'h13121110, 1'b0);
        chk("burst_cnt", 32'(bus.count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("burst_d", 32'(bus.data_out), 32'h10 + 32'(k));
            cyc(4'b0000, 32'h0, 1'b1);
        end
        chk("burst_vld", 32'(bus.valid_out), 32'h0);

        // Sparse compaction.
        cyc(4'b1010, 32'hA300A100, 1'b0);
        chk("sp_cnt", 32'(bus.count), 32'd2);
        chk("sp_d0", 32'(bus.data_out), 32'hA1);
        cyc(4'b0000, 32'h0, 1'b1);
        chk("sp_d1", 32'(bus.data_out), 32'hA3);
        cyc(4'b0000, 32'h0, 1'b1);
        chk("sp_vld", 32'(bus.valid_out), 32'h0);

        // Fill to full; held writes blocked.
        cyc(4'b1111, 32'h03020100, 1'b0);
        cyc(4'b1111, 32'h07060504, 1'b0);
        chk("full_cnt", 32'(bus.count), 32'd8);
        chk("full_rdy", 32'(bus.ready_in), 32'h0);
        cyc(4'b1111, 32'hEEEEEEEE, 1'b0);
        chk("full_hold", 32'(bus.count), 32'd8);
        chk("full_head", 32'(bus.data_out), 32'h00);
        cyc(4'b1111, 32'hEEEEEEEE, 1'b1);
        chk("full_rd_rdy", 32'(bus.ready_in), 32'h1);
        chk("full_rd_cnt", 32'(bus.count), 32'd7);

        // Partial grant at count=6.
        cyc(4'b0000, 32'h0, 1'b1);
        chk("pg_rdy", 32'(bus.ready_in), 32'h3);
        cyc(4'b1111, 32'h23222120, 1'b0);
        chk("pg_cnt", 32'(bus.count), 32'd8);
        cyc(4'b1100, 32'h23220000, 1'b1);
        chk("pg_blk", 32'(bus.count), 32'd7);
        repeat (3) cyc(4'b0000, 32'h0, 1'b1);
        chk("pg_cnt4", 32'(bus.count), 32'd4);
        cyc(4'b1100, 32'h23220000, 1'b0);
        chk("pg_cnt6", 32'(bus.count), 32'd6);
        repeat (6) cyc(4'b0000, 32'h0, 1'b1);
        chk("pg_vld", 32'(bus.valid_out), 32'h0);

        // Wrap with simultaneous traffic from a fresh reset.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(4'b1111, 32'h33323130, 1'b0);
        cyc(4'b0011, 32'h00003534, 1'b0);
        repeat (5) cyc(4'b0000, 32'h0, 1'b1);
        chk("wr_pre_d", 32'(bus.data_out), 32'h35);
        cyc(4'b1111, 32'hB3B2B1B0, 1'b1);
        chk("wr_cnt", 32'(bus.count), 32'd4);
        chk("wr_d0", 32'(bus.data_out), 32'hB0);
        cyc(4'b0000, 32'h0, 1'b1);
        chk("wr_d1", 32'(bus.data_out), 32'hB1);
        cyc(4'b0000, 32'h0, 1'b1);
        chk("wr_d2", 32'(bus.data_out), 32'hB2);

        // Reset mid-drain with live inputs.
        reset = 1'b1;
        bus.valid_in  = 4'b1111;
        bus.ready_out = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        chk("mr_cnt",  32'(bus.count),     32'd0);
        chk("mr_vld",  32'(bus.valid_out), 32'h0);
        chk("mr_dout", 32'(bus.data_out),  32'h0);
        chk("mr_rdy",  32'(bus.ready_in),  32'hF);

        // Read while empty is ignored.
        cyc(4'b0000, 32'h0, 1'b1);
        chk("er_cnt", 32'(bus.count), 32'd0);
        cyc(4'b0001, 32'h0000005A, 1'b1);
        chk("er_d", 32'(bus.data_out), 32'h5A);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            cyc(4'($urandom_range(0, 15)), $urandom,
                1'($urandom_range(0, 1)));
        end
        repeat (DEPTH + 2) cyc(4'b0000, 32'h0, 1'b1);
        chk("end_vld", 32'(bus.valid_out), 32'h0);
        chk("end_sb", 32'(sb.size()), 32'd0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
